// File: rtl/usb_line_pkg.sv
// Shared USB line definitions: FSM states for line drivers, line-state
// encodings, and small helpers used by the host-side drivers and receivers.
package usb_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_SE0 = 3'd1,
    ST_EOP_SE0 = 3'd2,
    ST_DRIVE_J = 3'd3,
    ST_RECOVER = 3'd4
  } line_state_e;

  localparam logic [1:0] SE0  = 2'b00;
  localparam logic [1:0] FS_J = 2'b10;
  localparam logic [1:0] LS_J = 2'b01;

  // Largest of four unsigned values; used to size phase counters.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Only the two legal J encodings are kept; SE0/SE1 fall back to full-speed J.
  function automatic logic [1:0] sanitize_j(input logic [1:0] j);
    return ((j == FS_J) || (j == LS_J)) ? j : FS_J;
  endfunction

endpackage

// File: rtl/usb_phase_timer.sv
// Down-counting phase timer: loaded on phase entry, decremented each cycle
// of the phase, and flagging expiry on the last cycle (count == 1).
module usb_phase_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             load_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  // Counter register: load has priority over decrement; never wraps below zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/usb_host_reset_driver.sv
// Host-side line driver: generates a bus reset (long SE0) or an EOP/keep-alive
// (short SE0), follows either with J, then releases the pads before signalling done.
module usb_host_reset_driver
  import usb_line_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = 24,
  parameter int unsigned EOP_SE0_CYCLES  = 2,
  parameter int unsigned EOP_J_CYCLES    = 1,
  parameter int unsigned RECOVERY_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       reset_req,
  input  logic       eop_req,
  input  logic [1:0] j_state,
  output logic       busy,
  output logic       done,
  output logic [1:0] usb_out,
  output logic       usb_oe
);

  localparam int unsigned MAX_P = max4(RESET_CYCLES, EOP_SE0_CYCLES, EOP_J_CYCLES, RECOVERY_CYCLES);
  localparam int CNT_W = $clog2(MAX_P + 1);

  line_state_e      state_q, state_d;
  logic [1:0]       j_q, j_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       out_q, out_d;
  logic             oe_q, oe_d;

  logic             tmr_load;
  logic             tmr_dec;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expired;

  usb_phase_timer #(.WIDTH(CNT_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_val_i (tmr_val),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_expired)
  );

  // Next-state logic plus next values of the registered outputs (derived from
  // the next state so every output change lands on the same edge as the state).
  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Reset outranks EOP; a simultaneous eop_req is simply dropped.
        if (reset_req) begin
          state_d  = ST_RST_SE0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(RESET_CYCLES);
          j_d      = sanitize_j(j_state);
        end else if (eop_req) begin
          state_d  = ST_EOP_SE0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(EOP_SE0_CYCLES);
          j_d      = sanitize_j(j_state);
        end
      end
      ST_RST_SE0, ST_EOP_SE0: begin
        if (tmr_expired) begin
          state_d  = ST_DRIVE_J;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(EOP_J_CYCLES);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DRIVE_J: begin
        if (tmr_expired) begin
          state_d  = ST_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(RECOVERY_CYCLES);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_RECOVER) && (state_d == ST_IDLE);
    oe_d   = (state_d == ST_RST_SE0) || (state_d == ST_EOP_SE0) || (state_d == ST_DRIVE_J);
    out_d  = (state_d == ST_DRIVE_J) ? j_d : SE0;
  end

  // State, latched J and output registers; reset releases the line at once.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      j_q     <= FS_J;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= SE0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign usb_out = out_q;
  assign usb_oe  = oe_q;

endmodule

// File: doc/usb_host_reset_driver.md
Name: usb_host_reset_driver

Overview:
- Transmit-side counterpart to the host-port speed/reset detector: drives the D+/D- line pair to generate a bus reset (long SE0) or a single EOP/keep-alive (short SE0 then J).
- The line is released (output enable low) afterwards, so the far end can resume driving and the detector can re-sample idle.
- Sits between port-control logic (requests) and the bidirectional USB pad buffers.

Parameters:
- RESET_CYCLES, 24: SE0 length for bus reset; must exceed the detector's reset threshold by at least 2 cycles.
- EOP_SE0_CYCLES, 2: SE0 length of an EOP/keep-alive.
- EOP_J_CYCLES, 1: J drive length after any SE0 phase.
- RECOVERY_CYCLES, 4: cycles with output enable low before completion is signalled.
- All parameters must be >= 1.

Ports:
- clock, input, 1: sole clock; all logic on its rising edge.
- reset_n, input, 1: reset, synchronous, active-low.
- reset_req, input, 1: request a bus reset; sampled only in IDLE.
- eop_req, input, 1: request an EOP/keep-alive; sampled only in IDLE.
- j_state, input, 2: J encoding from the speed detector; 2'b10 = full-speed, 2'b01 = low-speed.
- busy, output, 1: sequence in progress.
- done, output, 1: one-cycle completion pulse.
- usb_out, output, 2: {D+, D-} drive value.
- usb_oe, output, 1: pad output enable.

Behaviour:
- All outputs are registered.
- Reset (reset_n low at an edge): state=IDLE, busy=0, done=0, usb_out=2'b00, usb_oe=0, counter=0, latched J=2'b10.
  - Applies mid-sequence too: the line is released immediately (next cycle) with no EOP and no done pulse.
- States: IDLE, RST_SE0, EOP_SE0, DRIVE_J, RECOVER.
- IDLE:
  - reset_req=1 at edge N: go to RST_SE0 and load the counter with RESET_CYCLES.
  - Otherwise eop_req=1: go to EOP_SE0 and load EOP_SE0_CYCLES.
  - Both asserted: reset wins; eop_req is dropped.
  - On acceptance, latch j_state. If j_state is 2'b00 or 2'b11, latch 2'b10 instead.
- RST_SE0 / EOP_SE0:
  - Drive usb_oe=1, usb_out=2'b00, from cycle N+1 for exactly the loaded count.
  - Then go to DRIVE_J.
- DRIVE_J:
  - Drive usb_oe=1, usb_out=latched J for exactly EOP_J_CYCLES cycles.
  - Then go to RECOVER.
- RECOVER:
  - Drive usb_oe=0, usb_out=2'b00 for exactly RECOVERY_CYCLES cycles.
  - Then go to IDLE.
- busy:
  - 1 from cycle N+1 through the last RECOVER cycle.
  - 0 in IDLE.
- done:
  - 1 for exactly one cycle: the first IDLE cycle after RECOVER.
  - A request present in that cycle is accepted (back-to-back allowed).
- Requests asserted while busy are ignored (no queueing). Requesters hold or re-issue after done.
- j_state changes mid-sequence have no effect; the latched value is used.
- Counter:
  - Width is $clog2(max parameter + 1).
  - Loaded on each state entry, decrements each cycle; the phase ends when it is 1.
  - No wrap-around is reachable.

Decomposition:
- Shared package usb_line_pkg:
  - State enum.
  - Line constants: SE0=2'b00, FS_J=2'b10, LS_J=2'b01.
  - Shared with the detector and future line receivers.
- One sub-module: usb_phase_timer (load value, load strobe, decrement, expired flag, parameterised width), reused by the FSM for every phase.

Test Plan:
- Defaults, j_state=2'b10, reset_req pulse at cycle 0:
  - usb_oe=1, usb_out=00 for cycles 1-24.
  - usb_out=10 at cycle 25.
  - usb_oe=0 for cycles 26-29.
  - done=1 at cycle 30 only; busy=1 for cycles 1-29.
- j_state=2'b01, eop_req pulse:
  - SE0 for 2 cycles, usb_out=01 for 1 cycle, release for 4 cycles, done after 7 busy cycles.
- reset_req and eop_req high together in IDLE:
  - Reset sequence only (24 SE0 cycles); no EOP follows.
- reset_n low at SE0 cycle 10:
  - Next cycle usb_oe=0, busy=0, done never pulses.
  - New reset_req afterwards gives a full 24-cycle SE0.
- eop_req held continuously:
  - A new sequence starts in the same cycle done=1.
  - eop_req pulses during busy are ignored.
- j_state=2'b11 at acceptance, then changed to 01 mid-sequence:
  - J phase drives 10.
- Loopback into the speed detector (RESET_TIMER=20): detector reset asserts during the SE0 phase and deasserts after the J phase.
